// File: rtl/aes128_round_ctrl.sv
// aes128_round_ctrl -- iterative AES-128 encryption sequencer.
//
// This block encrypts one 128-bit block in NR (=10) round cycles, one round per clock.
// The round key is expanded on the fly, next to the data path.
// The job is started with a valid/ready handshake, and the result is released the same way.
// Jobs never overlap: a new block is accepted only in IDLE.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   plaintext/key valid
//   in_ready   block can be accepted (IDLE and out of reset)
//   plaintext  input block, byte 0 = bits [127:120], column-major
//   key        cipher key, same byte order
//   out_valid  ciphertext valid (DONE)
//   out_ready  sink accepts ciphertext
//   ciphertext registered result, held through DONE
//   busy       high in ROUND or DONE
//   round_o    current round number (0 in IDLE)
module aes128_round_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy,
  output logic [3:0]   round_o
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  // AES S-box. Entry 0 is held in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] base;
    base = 11'd2040 - {x, 3'b000};
    return SBOX[base +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  fsm_t         fsm_reg, fsm_next;
  logic [127:0] state_reg, state_next;
  logic [127:0] rk_reg, rk_next;
  logic [127:0] ct_reg, ct_next;
  logic [3:0]   round_reg, round_next;
  logic [7:0]   rcon_reg, rcon_next;

  // Round data path: SubBytes -> ShiftRows -> MixColumns.
  logic [127:0] sb_state, sr_state, mc_state;
  // Key schedule
  logic [31:0]  w0, w1, w2, w3, rot_w3, sub_rot, nw0, nw1, nw2, nw3;
  logic [127:0] next_rk;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_byte
      // Byte gi sits at row gi%4 and column gi/4.
      // After ShiftRows, row r of column c takes the byte from column (c+r)%4.
      localparam int R   = gi % 4;
      localparam int C   = gi / 4;
      localparam int SRC = R + 4 * ((C + R) % 4);
      assign sb_state[127-8*gi -: 8] = sbox(state_reg[127-8*gi -: 8]);
      assign sr_state[127-8*gi -: 8] = sb_state[127-8*SRC -: 8];
    end
    for (gi = 0; gi < 4; gi++) begin : g_col
      assign mc_state[127-32*gi -: 32] = mix_col(sr_state[127-32*gi -: 32]);
      assign sub_rot[31-8*gi -: 8]     = sbox(rot_w3[31-8*gi -: 8]);
    end
  endgenerate

  assign {w0, w1, w2, w3} = rk_reg;
  assign rot_w3  = {w3[23:0], w3[31:24]};
  assign nw0     = w0 ^ sub_rot ^ {rcon_reg, 24'h0};
  assign nw1     = w1 ^ nw0;
  assign nw2     = w2 ^ nw1;
  assign nw3     = w3 ^ nw2;
  assign next_rk = {nw0, nw1, nw2, nw3};

  always_comb begin
    fsm_next   = fsm_reg;
    state_next = state_reg;
    rk_next    = rk_reg;
    ct_next    = ct_reg;
    round_next = round_reg;
    rcon_next  = rcon_reg;
    case (fsm_reg)
      IDLE: begin
        // in_ready is high here whenever the register can update.
        // So in_valid alone is enough to mark an accept.
        if (in_valid) begin
          state_next = plaintext ^ key;
          rk_next    = key;
          round_next = 4'd1;
          rcon_next  = 8'h01;
          fsm_next   = ROUND;
        end
      end
      ROUND: begin
        rk_next   = next_rk;
        rcon_next = xtime(rcon_reg);
        if (round_reg == LAST_ROUND) begin
          // The last round skips MixColumns.
          // round_reg stays at LAST_ROUND through DONE.
          state_next = sr_state ^ next_rk;
          ct_next    = sr_state ^ next_rk;
          fsm_next   = DONE;
        end else begin
          state_next = mc_state ^ next_rk;
          round_next = round_reg + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          fsm_next   = IDLE;
          round_next = 4'd0;
        end
      end
      default: fsm_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_reg   <= IDLE;
      state_reg <= '0;
      rk_reg    <= '0;
      ct_reg    <= '0;
      round_reg <= 4'd0;
      rcon_reg  <= 8'h01;
    end else begin
      fsm_reg   <= fsm_next;
      state_reg <= state_next;
      rk_reg    <= rk_next;
      ct_reg    <= ct_next;
      round_reg <= round_next;
      rcon_reg  <= rcon_next;
    end
  end

  assign in_ready   = (fsm_reg == IDLE) && rst_n;
  assign busy       = (fsm_reg != IDLE);
  assign out_valid  = (fsm_reg == DONE);
  assign ciphertext = ct_reg;
  assign round_o    = round_reg;

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// tb_aes128_round_ctrl -- scoreboard bench for aes128_round_ctrl.
// The stimulus side pushes the expected ciphertext and the accept cycle into a queue.
// A monitor compares the queue against the DUT whenever out_valid is high.
// Random jobs are checked against a byte-array AES model.
// That model derives its S-box from the GF(2^8) inverse plus the affine map.
module tb_aes128_round_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;
  logic         busy;
  logic [3:0]   round_o;

  aes128_round_ctrl #(.NR(10)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .plaintext(plaintext), .key(key), .out_valid(out_valid), .out_ready(out_ready),
    .ciphertext(ciphertext), .busy(busy), .round_o(round_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int jobs  = 0;

  typedef struct {
    logic [127:0] ct;
    int           acc;
  } exp_t;
  exp_t exp_q[$];
  logic seen_valid = 1'b0;

  logic [7:0] sb [256];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      b = inv;
      sb[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  // State after nr rounds (nr = 10 gives the ciphertext).
  function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [127:0] k, input int nr);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  w [44];
    logic [7:0]   rc = 8'h01;
    logic [31:0]  tmp;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[4*(((i/4) + (i%4)) % 4) + (i%4)]];
      if (r < 10) begin
        for (int c = 0; c < 4; c++)
          for (int j = 0; j < 4; j++)
            s[4*c+j] = gmul(t[4*c+j], 8'h02) ^ gmul(t[4*c+(j+1)%4], 8'h03) ^
                       t[4*c+(j+2)%4] ^ t[4*c+(j+3)%4];
      end else begin
        s = t;
      end
      for (int i = 0; i < 16; i++) s[i] ^= w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      seen_valid = 1'b0;
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", {127'd0, out_valid}, 128'd0);
      end else begin
        if (!seen_valid) begin
          check("latency", 128'(cyc - exp_q[0].acc), 128'd10);
          seen_valid = 1'b1;
        end
        check("ciphertext", ciphertext, exp_q[0].ct);
        if (out_ready) begin
          jobs++;
          $display("[TB] job %0d ct=%h exp=%h", jobs, ciphertext, exp_q[0].ct);
          void'(exp_q.pop_front());
          seen_valid = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] p, input logic [127:0] k, input logic [127:0] exp_ct);
    int n = 0;
    exp_t e;
    while (!in_ready && n < 50) begin step(); n++; end
    check("in_ready_before_send", {127'd0, in_ready}, 128'd1);
    in_valid  = 1'b1;
    plaintext = p;
    key       = k;
    step();
    in_valid  = 1'b0;
    plaintext = {$urandom, $urandom, $urandom, $urandom};
    key       = {$urandom, $urandom, $urandom, $urandom};
    e.ct  = exp_ct;
    e.acc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin step(); n++; end
    check("drain", 128'(exp_q.size()), 128'd0);
  endtask

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] R1_B  = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  initial begin
    logic [127:0] rp, rk;
    int n;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    plaintext = '0; key = '0;
    build_sbox();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_in_ready", {127'd0, in_ready}, 128'd0);
    check("rst_round_o", {124'd0, round_o}, 128'd0);
    check("rst_ciphertext", ciphertext, 128'd0);
    rst_n = 1'b1;
    #1;
    check("in_ready_after_release", {127'd0, in_ready}, 128'd1);
    step();

    // App. B with round-1 probe
    send(PT_B, KEY_B, CT_B);
    step();
    check("round1_state", dut.state_reg, R1_B);
    check("round1_round_o", {124'd0, round_o}, 128'd2);
    check("busy_in_round", {127'd0, busy}, 128'd1);
    drain(30);
    check("idle_after_b", {127'd0, out_valid}, 128'd0);

    // App. C.1
    send(PT_C, KEY_C, CT_C);
    drain(30);

    // Backpressure
    out_ready = 1'b0;
    send(PT_B, KEY_B, CT_B);
    n = 0;
    while (!out_valid && n < 30) begin step(); n++; end
    check("bp_out_valid_seen", {127'd0, out_valid}, 128'd1);
    for (int i = 0; i < 7; i++) begin
      check("bp_out_valid_held", {127'd0, out_valid}, 128'd1);
      check("bp_in_ready_low", {127'd0, in_ready}, 128'd0);
      check("bp_round_o", {124'd0, round_o}, 128'd10);
      step();
    end
    out_ready = 1'b1;
    step();
    check("bp_in_ready_back", {127'd0, in_ready}, 128'd1);
    check("bp_out_valid_low", {127'd0, out_valid}, 128'd0);
    check("bp_round_o_idle", {124'd0, round_o}, 128'd0);

    // Busy guard
    send(PT_B, KEY_B, CT_B);
    repeat (3) step();
    in_valid = 1'b1; plaintext = '0; key = '0;
    for (int i = 0; i < 3; i++) begin
      check("guard_in_ready_low", {127'd0, in_ready}, 128'd0);
      step();
    end
    in_valid = 1'b0;
    drain(30);

    // Reset at round 5
    send(PT_C, KEY_C, CT_C);
    repeat (4) step();
    check("pre_reset_round", {124'd0, round_o}, 128'd5);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("mid_rst_busy", {127'd0, busy}, 128'd0);
    check("mid_rst_in_ready", {127'd0, in_ready}, 128'd0);
    check("mid_rst_round_o", {124'd0, round_o}, 128'd0);
    check("mid_rst_ciphertext", ciphertext, 128'd0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (15) step();
    check("post_rst_idle", {127'd0, in_ready}, 128'd1);
    send(PT_C, KEY_C, CT_C);
    drain(30);

    // Randomized jobs with random backpressure
    for (int j = 0; j < 10; j++) begin
      rp = {$urandom, $urandom, $urandom, $urandom};
      rk = {$urandom, $urandom, $urandom, $urandom};
      send(rp, rk, aes_model(rp, rk, 10));
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
        out_ready = 1'($urandom_range(0, 1));
        step();
        n++;
      end
      check("rand_drain", 128'(exp_q.size()), 128'd0);
      out_ready = 1'b1;
      repeat ($urandom_range(0, 3)) step();
    end

    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
